q8_8_div_seq: RTL and testbench



---
 rtl/q8_8_pkg.sv | 24 ++
 rtl/q8_8_div_step.sv | 30 +++
 rtl/q8_8_div_seq.sv | 146 ++++++++++++++
 tb/tb_q8_8_div_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/q8_8_pkg.sv
// rtl/q8_8_pkg.sv - shared Q8.8 constants, divider state encoding and magnitude helper
package q8_8_pkg;

    localparam int          Q_WIDTH = 16;
    localparam int          Q_FRAC  = 8;
    localparam logic [15:0] Q_MAX   = 16'h7FFF;
    localparam logic [15:0] Q_MIN   = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } div_state_t;

    // Magnitude of a two's-complement Q8.8 value, one bit wider so that
    // 0x8000 maps to +32768 instead of wrapping back to itself.
    function automatic logic [Q_WIDTH:0] q_abs(input logic [Q_WIDTH-1:0] v);
        logic [Q_WIDTH:0] ext;
        ext = {v[Q_WIDTH-1], v};
        return v[Q_WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/q8_8_div_step.sv
// rtl/q8_8_div_step.sv - one combinational radix-2 restoring division iteration
//
// Ports:
//   rem       current partial remainder (always < divisor magnitude)
//   next_bit  next numerator bit, MSB first
//   dmag      divisor magnitude
//   rem_next  partial remainder after shift and trial subtract
//   q_bit     quotient bit produced by this iteration
module q8_8_div_step #(
    parameter int MAG_W = 17,
    parameter int REM_W = 18
) (
    input  logic [REM_W-1:0] rem,
    input  logic             next_bit,
    input  logic [MAG_W-1:0] dmag,
    output logic [REM_W-1:0] rem_next,
    output logic             q_bit
);

    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] dext;

    always_comb begin
        shifted  = {rem[REM_W-2:0], next_bit};
        dext     = {{(REM_W-MAG_W){1'b0}}, dmag};
        q_bit    = (shifted >= dext);
        rem_next = q_bit ? (shifted - dext) : shifted;
    end

endmodule

// File: rtl/q8_8_div_seq.sv
// rtl/q8_8_div_seq.sv - sequential signed Q8.8 restoring divider with saturation
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand channel, dividend and divisor (signed Q8.8)
//   out_valid/out_ready     result channel
//   quotient                saturated, truncated-toward-zero Q8.8 quotient
//   div_by_zero, overflow   status flags, qualified by out_valid
module q8_8_div_seq
    import q8_8_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int FRAC  = Q_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int MAG_W = WIDTH + 1;
    localparam int NUM_W = MAG_W + FRAC;
    localparam int REM_W = MAG_W + 1;
    localparam int CNT_W = $clog2(NUM_W);

    localparam logic [NUM_W-1:0] POS_LIMIT = NUM_W'(Q_MAX);
    localparam logic [NUM_W-1:0] NEG_LIMIT = NUM_W'(Q_MIN);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH + FRAC);

    div_state_t       state;
    logic             sign;
    logic [NUM_W-1:0] num;
    logic [NUM_W-1:0] quo;
    logic [REM_W-1:0] rem;
    logic [MAG_W-1:0] dmag;
    logic [CNT_W-1:0] cnt;

    logic [REM_W-1:0] rem_next;
    logic             q_bit;

    q8_8_div_step #(
        .MAG_W (MAG_W),
        .REM_W (REM_W)
    ) u_step (
        .rem      (rem),
        .next_bit (num[NUM_W-1]),
        .dmag     (dmag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            sign        <= 1'b0;
            num         <= '0;
            quo         <= '0;
            rem         <= '0;
            dmag        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        num      <= {q_abs(dividend), {FRAC{1'b0}}};
                        dmag     <= q_abs(divisor);
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= CNT_LOAD;
                        overflow <= 1'b0;
                        if (divisor == '0) begin
                            // Result is known now; FIN only spends the one
                            // edge that publishes it on the output channel.
                            div_by_zero <= 1'b1;
                            quotient    <= dividend[WIDTH-1] ? Q_MIN : Q_MAX;
                            state       <= FIN;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end

                CALC: begin
                    // The counter indexes the numerator bit being consumed,
                    // so it runs from NUM_W-1 down to 0 inclusive.
                    rem <= rem_next;
                    quo <= {quo[NUM_W-2:0], q_bit};
                    num <= {num[NUM_W-2:0], 1'b0};
                    if (cnt == '0) begin
                        state <= FIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                FIN: begin
                    if (!div_by_zero) begin
                        if (!sign && (quo > POS_LIMIT)) begin
                            quotient <= Q_MAX;
                            overflow <= 1'b1;
                        end else if (sign && (quo > NEG_LIMIT)) begin
                            quotient <= Q_MIN;
                            overflow <= 1'b1;
                        end else begin
                            // Zero magnitude negates to zero, so no sign fix-up.
                            quotient <= sign ? (~quo[WIDTH-1:0] + 1'b1) : quo[WIDTH-1:0];
                            overflow <= 1'b0;
                        end
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q8_8_div_seq.sv
// tb/tb_q8_8_div_seq.sv - self-checking bench for q8_8_div_seq against an arithmetic model
module tb_q8_8_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    q8_8_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Real-number meaning: q = a / b in Q8.8, truncated toward zero, clamped.
    task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic dz, output logic ov);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            q  = (sa < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            r = (sa * 256) / sb;
            if (r > 32767) begin
                q  = 16'h7FFF;
                ov = 1'b1;
            end else if (r < -32768) begin
                q  = 16'h8000;
                ov = 1'b1;
            end else begin
                q = r[15:0];
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
        logic [15:0] eq;
        logic        edz, eov;
        int          lat;
        ref_div(a, b, eq, edz, eov);
        @(negedge clk);
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom();
        divisor  = $urandom();
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), edz ? 32'd1 : 32'd26);
        if (!out_valid) return;
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        chk({tag, " overflow"}, 32'(overflow), 32'(eov));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, " hold_q"}, {13'd0, div_by_zero, overflow, 1'b0, quotient},
                {13'd0, edz, eov, 1'b0, eq});
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " released"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    logic [15:0] dir_a [9] = '{16'h0100, 16'hFC80, 16'h0100, 16'hFF00, 16'h7F00,
                               16'h8000, 16'h8000, 16'h0100, 16'hFF00};
    logic [15:0] dir_b [9] = '{16'h0080, 16'h0200, 16'h0300, 16'h0300, 16'h0080,
                               16'hFF00, 16'h0100, 16'h0000, 16'h0000};

    initial begin
        logic [15:0] ra, rb;
        int          seen;

        repeat (2) @(posedge clk);
        #1;
        chk("reset state", {27'd0, in_ready, out_valid, div_by_zero, overflow, 1'b0},
            {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: plain, signed, truncation, saturation, divide-by-zero.
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i], 0);
        end

        // Backpressure: result must sit still while out_ready is low.
        run_op("hold", 16'hFC80, 16'h0200, 10);

        // Random operands, with some small divisors and zeros mixed in.
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom());
            case (i % 5)
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(0, 15)) | 16'h0001;
                2:       rb = 16'h8000;
                default: rb = 16'($urandom());
            endcase
            run_op($sformatf("rnd%0d", i), ra, rb, i % 3);
        end

        // Reset partway through CALC must abandon the operation.
        @(negedge clk);
        dividend = 16'h0100;
        divisor  = 16'h0300;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
        chk("midreset quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midreset no stale result", 32'(seen), 32'd0);
        run_op("after_reset", 16'hFF00, 16'h0300, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
